// File: rtl/i2c_reg_sequencer_pkg.sv
// Shared definitions for the table-driven I2C register sequencer.
// Holds the opcode values, the command-entry layout and field offsets,
// the sequencer state encoding and a helper that packs a table entry.
package i2c_reg_sequencer_pkg;

  localparam int unsigned ENTRY_W = 26;

  // Entry field offsets: {op[1:0], reg[7:0], data[7:0], mask[7:0]}
  localparam int unsigned OP_LSB   = 24;
  localparam int unsigned REG_LSB  = 16;
  localparam int unsigned DATA_LSB = 8;
  localparam int unsigned MASK_LSB = 0;

  localparam logic [1:0] OP_WRITE        = 2'd0;
  localparam logic [1:0] OP_WRITE_VERIFY = 2'd1;
  localparam logic [1:0] OP_DELAY        = 2'd2;
  localparam logic [1:0] OP_END          = 2'd3;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] reg_addr;
    logic [7:0] data;
    logic [7:0] mask;
  } cmd_t;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_ISSUE_WR = 4'd2;
  localparam logic [3:0] ST_WAIT_WR  = 4'd3;
  localparam logic [3:0] ST_ISSUE_RD = 4'd4;
  localparam logic [3:0] ST_WAIT_RD  = 4'd5;
  localparam logic [3:0] ST_FAIL     = 4'd6;
  localparam logic [3:0] ST_DLY      = 4'd7;
  localparam logic [3:0] ST_NEXT     = 4'd8;
  localparam logic [3:0] ST_DONE     = 4'd9;
  localparam logic [3:0] ST_ERROR    = 4'd10;

  // Build one table entry from its fields.
  function automatic logic [ENTRY_W-1:0] pack_cmd(input logic [1:0] op,
                                                  input logic [7:0] reg_addr,
                                                  input logic [7:0] data,
                                                  input logic [7:0] mask);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[OP_LSB   +: 2] = op;
    e[REG_LSB  +: 8] = reg_addr;
    e[DATA_LSB +: 8] = data;
    e[MASK_LSB +: 8] = mask;
    return e;
  endfunction

endpackage

// File: rtl/adv7513_cmd_rom.sv
// ADV7513 HDMI transmitter init table for i2c_reg_sequencer.
// A power-settle DELAY followed by the fixed register write list, then END.
// Ports:
//   cmd_idx     in  4   table index requested by the sequencer
//   cmd_entry_c out 26  combinational table entry for cmd_idx
module adv7513_cmd_rom
  import i2c_reg_sequencer_pkg::*;
(
  input  logic [3:0]         cmd_idx,
  output logic [ENTRY_W-1:0] cmd_entry_c
);

  // Purely combinational lookup; unused slots read as END.
  always_comb begin
    cmd_entry_c = pack_cmd(OP_END, 8'h00, 8'h00, 8'h00);
    case (cmd_idx)
      4'd0:  cmd_entry_c = pack_cmd(OP_DELAY, 8'h00, 8'h0A, 8'h00);
      4'd1:  cmd_entry_c = pack_cmd(OP_WRITE, 8'h41, 8'h10, 8'h00);
      4'd2:  cmd_entry_c = pack_cmd(OP_WRITE, 8'h98, 8'h03, 8'h00);
      4'd3:  cmd_entry_c = pack_cmd(OP_WRITE, 8'h9A, 8'hE0, 8'h00);
      4'd4:  cmd_entry_c = pack_cmd(OP_WRITE, 8'h9C, 8'h30, 8'h00);
      4'd5:  cmd_entry_c = pack_cmd(OP_WRITE, 8'h9D, 8'h61, 8'h00);
      4'd6:  cmd_entry_c = pack_cmd(OP_WRITE, 8'hA2, 8'hA4, 8'h00);
      4'd7:  cmd_entry_c = pack_cmd(OP_WRITE, 8'hA3, 8'hA4, 8'h00);
      4'd8:  cmd_entry_c = pack_cmd(OP_WRITE, 8'hE0, 8'hD0, 8'h00);
      4'd9:  cmd_entry_c = pack_cmd(OP_WRITE, 8'hF9, 8'h00, 8'h00);
      4'd10: cmd_entry_c = pack_cmd(OP_WRITE, 8'h15, 8'h00, 8'h00);
      4'd11: cmd_entry_c = pack_cmd(OP_WRITE, 8'h16, 8'h30, 8'h00);
      4'd12: cmd_entry_c = pack_cmd(OP_WRITE, 8'h17, 8'h02, 8'h00);
      4'd13: cmd_entry_c = pack_cmd(OP_WRITE, 8'h18, 8'h46, 8'h00);
      4'd14: cmd_entry_c = pack_cmd(OP_WRITE, 8'hAF, 8'h06, 8'h00);
      default: cmd_entry_c = pack_cmd(OP_END, 8'h00, 8'h00, 8'h00);
    endcase
  end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Table-driven I2C register-init sequencer.
// Walks an external command table (WRITE, WRITE_VERIFY, DELAY, END) and
// drives the request/response handshake of i2c_master, with per-command
// retry on bus error / verify miscompare and failing-index reporting.
// Ports:
//   clk, reset (async, active low), start (level)
//   cmd_idx / cmd_entry            : table lookup (entry valid same cycle)
//   i2c_chip_addr/reg_addr/data_in : request payload to i2c_master
//   i2c_write_en / i2c_read_en     : one-cycle request pulses
//   i2c_done/status/data_out       : completion from i2c_master
//   busy, done, error, err_idx     : sequence status
module i2c_reg_sequencer
  import i2c_reg_sequencer_pkg::*;
#(
  parameter logic [6:0]  CHIP_ADDR  = 7'h39,
  parameter int unsigned CMD_COUNT  = 16,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned DELAY_UNIT = 1024,
  parameter int unsigned IDX_W      = (CMD_COUNT > 1) ? $clog2(CMD_COUNT) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [IDX_W-1:0]   cmd_idx,
  input  logic [ENTRY_W-1:0] cmd_entry,
  output logic [6:0]         i2c_chip_addr,
  output logic [7:0]         i2c_reg_addr,
  output logic [7:0]         i2c_data_in,
  output logic               i2c_write_en,
  output logic               i2c_read_en,
  input  logic               i2c_done,
  input  logic [2:0]         i2c_status,
  input  logic [7:0]         i2c_data_out,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [IDX_W-1:0]   err_idx
);

  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned DLY_W = 8 + $clog2(DELAY_UNIT + 1);

  logic [3:0]       state;
  logic [3:0]       state_next;
  cmd_t             entry;
  logic [1:0]       cur_op;
  logic [7:0]       cur_mask;
  logic [RTY_W-1:0] retry;
  logic [DLY_W-1:0] dly_cnt;
  logic [DLY_W-1:0] dly_load;
  logic             last_cmd;
  logic             retry_left;
  logic             verify_ok;
  logic             rest_next;

  assign entry      = cmd_entry;
  assign dly_load   = DLY_W'(entry.data) * DLY_W'(DELAY_UNIT);
  assign last_cmd   = (cmd_idx == IDX_W'(CMD_COUNT - 1));
  assign retry_left = (retry < RTY_W'(MAX_RETRY));
  // i2c_data_in still holds the written value while the readback is pending.
  assign verify_ok  = (((i2c_data_out ^ i2c_data_in) & cur_mask) == 8'h00);
  assign rest_next  = (state_next == ST_IDLE) || (state_next == ST_DONE) ||
                      (state_next == ST_ERROR);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_next = ST_FETCH;
      ST_FETCH: begin
        case (entry.op)
          OP_WRITE, OP_WRITE_VERIFY: state_next = ST_ISSUE_WR;
          OP_DELAY:                  state_next = ST_DLY;
          default:                   state_next = ST_DONE;
        endcase
      end
      ST_ISSUE_WR: state_next = ST_WAIT_WR;
      ST_WAIT_WR: begin
        if (i2c_done) begin
          if (i2c_status != 3'd0)            state_next = ST_FAIL;
          else if (cur_op == OP_WRITE_VERIFY) state_next = ST_ISSUE_RD;
          else                                state_next = ST_NEXT;
        end
      end
      ST_ISSUE_RD: state_next = ST_WAIT_RD;
      ST_WAIT_RD: begin
        if (i2c_done) begin
          if ((i2c_status == 3'd0) && verify_ok) state_next = ST_NEXT;
          else                                   state_next = ST_FAIL;
        end
      end
      ST_FAIL: state_next = retry_left ? ST_ISSUE_WR : ST_ERROR;
      ST_DLY:  if (dly_cnt == '0) state_next = ST_NEXT;
      ST_NEXT: state_next = last_cmd ? ST_DONE : ST_FETCH;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; status/strobes follow the next state
  // so they are aligned with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_idx       <= '0;
      err_idx       <= '0;
      retry         <= '0;
      dly_cnt       <= '0;
      cur_op        <= OP_WRITE;
      cur_mask      <= 8'h00;
      i2c_chip_addr <= 7'h00;
      i2c_reg_addr  <= 8'h00;
      i2c_data_in   <= 8'h00;
      i2c_write_en  <= 1'b0;
      i2c_read_en   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      i2c_write_en <= (state_next == ST_ISSUE_WR);
      i2c_read_en  <= (state_next == ST_ISSUE_RD);
      busy         <= !rest_next;
      done         <= (state_next == ST_DONE);
      error        <= (state_next == ST_ERROR);
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            cmd_idx <= '0;
            err_idx <= '0;
            retry   <= '0;
          end
        end
        ST_FETCH: begin
          cur_op        <= entry.op;
          cur_mask      <= entry.mask;
          i2c_chip_addr <= CHIP_ADDR;
          i2c_reg_addr  <= entry.reg_addr;
          i2c_data_in   <= entry.data;
          dly_cnt       <= dly_load;
        end
        ST_FAIL: begin
          if (retry_left) retry   <= retry + RTY_W'(1);
          else            err_idx <= cmd_idx;
        end
        ST_DLY: if (dly_cnt != '0) dly_cnt <= dly_cnt - DLY_W'(1);
        ST_NEXT: begin
          retry <= '0;
          if (!last_cmd) cmd_idx <= cmd_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed self-checking bench for i2c_reg_sequencer with a behavioural
// i2c_master responder (fixed latency, scripted NACKs and readback data).
module tb_i2c_reg_sequencer;

  localparam int RESP_LAT = 4;
  localparam logic [1:0] W  = 2'd0;
  localparam logic [1:0] WV = 2'd1;
  localparam logic [1:0] DL = 2'd2;
  localparam logic [1:0] EN = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  cmd_idx;
  logic [25:0] cmd_entry;
  logic [6:0]  i2c_chip_addr;
  logic [7:0]  i2c_reg_addr;
  logic [7:0]  i2c_data_in;
  logic        i2c_write_en;
  logic        i2c_read_en;
  logic        i2c_done = 1'b0;
  logic [2:0]  i2c_status = 3'd0;
  logic [7:0]  i2c_data_out = 8'h00;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  err_idx;

  logic [25:0] tbl [8];
  int          nack_left [8];
  int          wr_per_idx [8];
  logic [7:0]  wr_reg [64];
  logic [7:0]  wr_data [64];
  logic [6:0]  wr_chip [64];
  int          wr_cyc [64];
  int          done_cyc [64];
  int          wr_count, rd_count, done_count, proto_viol;
  logic [7:0]  rb_val;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign cmd_entry = tbl[cmd_idx];

  i2c_reg_sequencer #(
    .CHIP_ADDR (7'h39),
    .CMD_COUNT (5),
    .MAX_RETRY (3),
    .DELAY_UNIT(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cmd_idx      (cmd_idx),
    .cmd_entry    (cmd_entry),
    .i2c_chip_addr(i2c_chip_addr),
    .i2c_reg_addr (i2c_reg_addr),
    .i2c_data_in  (i2c_data_in),
    .i2c_write_en (i2c_write_en),
    .i2c_read_en  (i2c_read_en),
    .i2c_done     (i2c_done),
    .i2c_status   (i2c_status),
    .i2c_data_out (i2c_data_out),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_idx      (err_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [25:0] mk(input logic [1:0] op, input logic [7:0] r,
                                     input logic [7:0] d, input logic [7:0] m);
    mk = {op, r, d, m};
  endfunction

  // i2c_master model: accepts one request, answers RESP_LAT negedges later.
  initial begin : responder
    bit pend;
    bit is_rd;
    bit nack;
    int lat;
    int idx;
    pend = 1'b0; is_rd = 1'b0; nack = 1'b0; lat = 0; idx = 0;
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_status = 3'd0;
      i2c_data_out = 8'h00;
      if (pend) begin
        if (i2c_write_en || i2c_read_en) proto_viol++;
        lat--;
        if (lat == 0) begin
          pend = 1'b0;
          i2c_done = 1'b1;
          i2c_status = nack ? 3'd1 : 3'd0;
          i2c_data_out = is_rd ? rb_val : 8'h5A;
          if (done_count < 64) done_cyc[done_count] = cyc;
          done_count++;
        end
      end else if (i2c_write_en || i2c_read_en) begin
        is_rd = i2c_read_en;
        idx = int'(cmd_idx);
        nack = 1'b0;
        if (is_rd) rd_count++;
        else begin
          if (wr_count < 64) begin
            wr_reg[wr_count]  = i2c_reg_addr;
            wr_data[wr_count] = i2c_data_in;
            wr_chip[wr_count] = i2c_chip_addr;
            wr_cyc[wr_count]  = cyc;
          end
          wr_count++;
          wr_per_idx[idx]++;
          if (nack_left[idx] > 0) begin
            nack = 1'b1;
            nack_left[idx]--;
          end
        end
        pend = 1'b1;
        lat = RESP_LAT;
      end
    end
  end

  task automatic clear_log;
    wr_count = 0; rd_count = 0; done_count = 0; proto_viol = 0; rb_val = 8'h00;
    for (int i = 0; i < 8; i++) begin
      nack_left[i] = 0;
      wr_per_idx[i] = 0;
      tbl[i] = mk(EN, 8'h00, 8'h00, 8'h00);
    end
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(done || error) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!(done || error)) begin
      n_bad++;
      $display("FAIL %s.timeout: no done/error after %0d cycles", name, n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0;
    clear_log();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, i2c_write_en, i2c_read_en} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset.flags: got %b want 00000", {busy, done, error, i2c_write_en, i2c_read_en});
    end
    n_cmp++;
    if ({i2c_chip_addr, i2c_reg_addr, i2c_data_in} !== 23'h0) begin
      n_bad++;
      $display("FAIL reset.payload: got %h/%h/%h want 0", i2c_chip_addr, i2c_reg_addr, i2c_data_in);
    end
    n_cmp++;
    if ({cmd_idx, err_idx} !== 6'h0) begin
      n_bad++;
      $display("FAIL reset.idx: got %0d/%0d want 0/0", cmd_idx, err_idx);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, i2c_write_en} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset.idle_after_release: got %b want 0000", {busy, done, error, i2c_write_en});
    end
  endtask

  task automatic test_three_writes;
    logic [7:0] er [3];
    logic [7:0] ed [3];
    er = '{8'h41, 8'h98, 8'hAF};
    ed = '{8'h00, 8'h03, 8'h02};
    clear_log();
    for (int i = 0; i < 3; i++) tbl[i] = mk(W, er[i], ed[i], 8'h00);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if ({i2c_write_en, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL three.fetch_cycle: got we/busy=%b want 01", {i2c_write_en, busy});
    end
    @(negedge clk);
    n_cmp++;
    if ({i2c_write_en, i2c_chip_addr, i2c_reg_addr, i2c_data_in} !== {1'b1, 7'h39, 8'h41, 8'h00}) begin
      n_bad++;
      $display("FAIL three.first_issue: got we=%b chip=%h reg=%h data=%h want 1/39/41/00",
               i2c_write_en, i2c_chip_addr, i2c_reg_addr, i2c_data_in);
    end
    @(negedge clk);
    n_cmp++;
    if (i2c_write_en !== 1'b0) begin
      n_bad++;
      $display("FAIL three.pulse_width: got we=%b want 0", i2c_write_en);
    end
    wait_end("three");
    n_cmp++;
    if (wr_count !== 3 || rd_count !== 0) begin
      n_bad++;
      $display("FAIL three.counts: got wr=%0d rd=%0d want 3/0", wr_count, rd_count);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({wr_chip[i], wr_reg[i], wr_data[i]} !== {7'h39, er[i], ed[i]}) begin
        n_bad++;
        $display("FAIL three.write%0d: got %h/%h/%h want 39/%h/%h", i, wr_chip[i], wr_reg[i], wr_data[i], er[i], ed[i]);
      end
    end
    n_cmp++;
    if ({done, error, busy, proto_viol == 0} !== 4'b1001) begin
      n_bad++;
      $display("FAIL three.status: got done=%b err=%b busy=%b viol=%0d want 1/0/0/0", done, error, busy, proto_viol);
    end
  endtask

  task automatic test_full_table;
    clear_log();
    for (int i = 0; i < 5; i++) tbl[i] = mk(W, 8'h10 + 8'(i), 8'h01 + 8'(i), 8'h00);
    pulse_start();
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_end("full");
    n_cmp++;
    if (wr_count !== 5 || wr_per_idx[0] !== 1) begin
      n_bad++;
      $display("FAIL full.counts: got wr=%0d idx0=%0d want 5/1", wr_count, wr_per_idx[0]);
    end
    n_cmp++;
    if ({wr_reg[4], wr_data[4], done, error} !== {8'h14, 8'h05, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL full.last: got reg=%h data=%h done=%b err=%b want 14/05/1/0", wr_reg[4], wr_data[4], done, error);
    end
  endtask

  task automatic test_nack_once;
    clear_log();
    tbl[0] = mk(W, 8'h41, 8'h00, 8'h00);
    tbl[1] = mk(W, 8'h98, 8'h03, 8'h00);
    tbl[2] = mk(W, 8'hAF, 8'h02, 8'h00);
    nack_left[1] = 1;
    pulse_start();
    wait_end("nack_once");
    n_cmp++;
    if ({wr_count[7:0], wr_per_idx[1][7:0], done, error} !== {8'd4, 8'd2, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL nack_once: got wr=%0d idx1=%0d done=%b err=%b want 4/2/1/0", wr_count, wr_per_idx[1], done, error);
    end
  endtask

  task automatic test_retry_per_cmd;
    clear_log();
    tbl[0] = mk(W, 8'h41, 8'h00, 8'h00);
    tbl[1] = mk(W, 8'h98, 8'h03, 8'h00);
    nack_left[0] = 3;
    nack_left[1] = 3;
    pulse_start();
    wait_end("retry_per_cmd");
    n_cmp++;
    if ({wr_per_idx[0][7:0], wr_per_idx[1][7:0], done, error} !== {8'd4, 8'd4, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL retry_per_cmd: got idx0=%0d idx1=%0d done=%b err=%b want 4/4/1/0",
               wr_per_idx[0], wr_per_idx[1], done, error);
    end
  endtask

  task automatic test_nack_always;
    clear_log();
    tbl[0] = mk(W, 8'h41, 8'h00, 8'h00);
    tbl[1] = mk(W, 8'h98, 8'h03, 8'h00);
    tbl[2] = mk(W, 8'hAF, 8'h02, 8'h00);
    nack_left[1] = 100;
    pulse_start();
    wait_end("nack_always");
    n_cmp++;
    if ({wr_per_idx[1][7:0], wr_per_idx[2][7:0]} !== {8'd4, 8'd0}) begin
      n_bad++;
      $display("FAIL nack_always.attempts: got idx1=%0d idx2=%0d want 4/0", wr_per_idx[1], wr_per_idx[2]);
    end
    n_cmp++;
    if ({error, done, busy, err_idx} !== {1'b1, 1'b0, 1'b0, 3'd1}) begin
      n_bad++;
      $display("FAIL nack_always.status: got err=%b done=%b busy=%b err_idx=%0d want 1/0/0/1", error, done, busy, err_idx);
    end
  endtask

  task automatic test_verify_pass;
    clear_log();
    tbl[0] = mk(WV, 8'hA2, 8'hA4, 8'hF0);
    rb_val = 8'hA0;
    pulse_start();
    n_cmp++;
    if ({error, err_idx} !== 4'h0) begin
      n_bad++;
      $display("FAIL verify_pass.err_cleared: got err=%b err_idx=%0d want 0/0", error, err_idx);
    end
    wait_end("verify_pass");
    n_cmp++;
    if ({wr_count[7:0], rd_count[7:0], done, error} !== {8'd1, 8'd1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL verify_pass: got wr=%0d rd=%0d done=%b err=%b want 1/1/1/0", wr_count, rd_count, done, error);
    end
  endtask

  task automatic test_verify_fail;
    clear_log();
    tbl[0] = mk(W, 8'h41, 8'h00, 8'h00);
    tbl[1] = mk(WV, 8'hA2, 8'hA4, 8'hFF);
    rb_val = 8'hA0;
    pulse_start();
    wait_end("verify_fail");
    n_cmp++;
    if ({wr_per_idx[1][7:0], rd_count[7:0]} !== {8'd4, 8'd4}) begin
      n_bad++;
      $display("FAIL verify_fail.attempts: got wr_idx1=%0d rd=%0d want 4/4", wr_per_idx[1], rd_count);
    end
    n_cmp++;
    if ({error, done, err_idx} !== {1'b1, 1'b0, 3'd1}) begin
      n_bad++;
      $display("FAIL verify_fail.status: got err=%b done=%b err_idx=%0d want 1/0/1", error, done, err_idx);
    end
  endtask

  task automatic test_delay;
    int gap;
    clear_log();
    tbl[0] = mk(W, 8'h41, 8'h00, 8'h00);
    tbl[1] = mk(DL, 8'h00, 8'h04, 8'h00);
    tbl[2] = mk(W, 8'h98, 8'h03, 8'h00);
    tbl[4] = mk(W, 8'hAF, 8'h02, 8'h00);
    pulse_start();
    wait_end("delay");
    gap = wr_cyc[1] - done_cyc[0];
    n_cmp++;
    if (gap < 32 || gap > 48) begin
      n_bad++;
      $display("FAIL delay.gap: got %0d cycles want 32..48", gap);
    end
    n_cmp++;
    if ({wr_count[7:0], wr_reg[1], done} !== {8'd2, 8'h98, 1'b1}) begin
      n_bad++;
      $display("FAIL delay.writes: got wr=%0d reg1=%h done=%b want 2/98/1", wr_count, wr_reg[1], done);
    end
  endtask

  task automatic test_end_early;
    clear_log();
    tbl[0] = mk(W, 8'h41, 8'h00, 8'h00);
    tbl[1] = mk(W, 8'h98, 8'h03, 8'h00);
    tbl[2] = mk(EN, 8'h00, 8'h00, 8'h00);
    tbl[3] = mk(W, 8'hAF, 8'h02, 8'h00);
    tbl[4] = mk(W, 8'h16, 8'h30, 8'h00);
    pulse_start();
    wait_end("end_early");
    n_cmp++;
    if ({wr_count[7:0], done, error} !== {8'd2, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL end_early: got wr=%0d done=%b err=%b want 2/1/0", wr_count, done, error);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    clear_log();
    tbl[0] = mk(W, 8'h41, 8'h00, 8'h00);
    tbl[1] = mk(W, 8'h98, 8'h03, 8'h00);
    pulse_start();
    n = 0;
    while (!i2c_write_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, error, i2c_write_en, i2c_read_en, i2c_chip_addr, i2c_reg_addr, cmd_idx} !== 26'h0) begin
      n_bad++;
      $display("FAIL reset_mid.immediate: got busy=%b we=%b chip=%h reg=%h idx=%0d want all 0",
               busy, i2c_write_en, i2c_chip_addr, i2c_reg_addr, cmd_idx);
    end
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, wr_count[7:0]} !== {3'b000, 8'd1}) begin
      n_bad++;
      $display("FAIL reset_mid.stray_done: got busy=%b done=%b err=%b wr=%0d want 0/0/0/1", busy, done, error, wr_count);
    end
    pulse_start();
    wait_end("reset_mid");
    n_cmp++;
    if ({wr_count[7:0], wr_reg[1], wr_per_idx[0][7:0], done} !== {8'd3, 8'h41, 8'd2, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid.restart: got wr=%0d reg1=%h idx0=%0d done=%b want 3/41/2/1",
               wr_count, wr_reg[1], wr_per_idx[0], done);
    end
  endtask

  initial begin
    test_reset();
    test_three_writes();
    test_full_table();
    test_nack_once();
    test_retry_per_cmd();
    test_nack_always();
    test_verify_pass();
    test_verify_fail();
    test_delay();
    test_end_early();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
